// File: rtl/btn_events_pkg.sv
// Shared definitions for the button event decoder.
//   state_e : decoder states (ARM, IDLE, PRESSED, LONG)
//   CNT_W   : width of the hold/repeat tick counter
//   sat_inc : counter increment that sticks at all-ones instead of wrapping
package btn_events_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2,
        LONG    = 2'd3
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_events_edge_det.sv
// Edge detector for the debounced button level.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   d          : level to watch
//   rise, fall : combinational strobes comparing d against its registered copy
// The registered copy resets to 1 so a level that is already high when reset
// releases is never mistaken for a fresh press.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic btn_q;

    // One-cycle delayed copy of the input level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b1;
        end else begin
            btn_q <= d;
        end
    end

    assign rise = d & ~btn_q;
    assign fall = ~d & btn_q;

endmodule

// File: rtl/btn_events.sv
// Button event decoder: turns a debounced button level into press, short-press,
// long-press and (optionally) auto-repeat pulses, timed in 1 ms tick units.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   ce1ms        : one-clock 1 ms tick enable
//   btn_db       : debounced button level, high = pressed
//   press        : pulse on an accepted press edge
//   short_press  : pulse on release of a hold shorter than LONG_MS ticks
//   long_press   : pulse when a hold reaches LONG_MS ticks
//   repeat_tick  : auto-repeat pulse every REPEAT_MS ticks after a long press
//   held         : high while a hold is in progress
// Optional feature: define BTN_AUTOREPEAT_EN to enable repeat_tick; otherwise
// repeat_tick is constant 0 and the LONG state does not count.
// All outputs are registered; each pulse lags its causing sample by one clock.
module btn_events
    import btn_events_pkg::*;
#(
    parameter int LONG_MS   = 500,
    parameter int REPEAT_MS = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce1ms,
    input  logic btn_db,
    output logic press,
    output logic short_press,
    output logic long_press,
    output logic repeat_tick,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MS - 1);
`endif

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;
    logic             short_q;
    logic             long_q;
    logic             rep_q;
    logic             held_q;
    logic             rise_s;
    logic             fall_s;

    edge_det u_edge_det (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (btn_db),
        .rise (rise_s),
        .fall (fall_s)
    );

    // Decoder FSM, tick counter and registered event outputs.
    // In PRESSED and LONG the registered level is known to be 1, so the fall
    // strobe is exactly "btn_db low". Release is tested before the tick so a
    // release coinciding with the LONG_MS-th tick still yields a short press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARM;
            cnt_q   <= '0;
            press_q <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            press_q <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            case (state_q)
                ARM: begin
                    held_q <= 1'b0;
                    if (!btn_db) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= ARM;
                    end
                end
                IDLE: begin
                    if (rise_s) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        held_q  <= 1'b0;
                    end
                end
                PRESSED: begin
                    if (fall_s) begin
                        state_q <= IDLE;
                        short_q <= 1'b1;
                        held_q  <= 1'b0;
                    end else if (ce1ms) begin
                        held_q <= 1'b1;
                        if (cnt_q == LONG_LAST) begin
                            state_q <= LONG;
                            long_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= PRESSED;
                            cnt_q   <= sat_inc(cnt_q);
                        end
                    end else begin
                        state_q <= PRESSED;
                        held_q  <= 1'b1;
                    end
                end
                LONG: begin
                    if (fall_s) begin
                        state_q <= IDLE;
                        held_q  <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                    end else if (ce1ms) begin
                        state_q <= LONG;
                        held_q  <= 1'b1;
                        if (cnt_q == REP_LAST) begin
                            rep_q <= 1'b1;
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= sat_inc(cnt_q);
                        end
`endif
                    end else begin
                        state_q <= LONG;
                        held_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ARM;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign press       = press_q;
    assign short_press = short_q;
    assign long_press  = long_q;
    assign held        = held_q;
`ifdef BTN_AUTOREPEAT_EN
    assign repeat_tick = rep_q;
`else
    assign repeat_tick = 1'b0;
`endif

endmodule

// File: doc/btn_events.md
BTN_EVENTS -- requirements
Module: btn_events

Interface
REQ-001 Parameter LONG_MS, default 500: hold length in ce1ms ticks that defines a long press (range 2..65535).
REQ-002 Parameter REPEAT_MS, default 100: auto-repeat period in ce1ms ticks after a long press (range 1..65535).
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ce1ms  input  1  one-clk-wide 1 ms clock enable, shared with the debouncer.
REQ-006 btn_db  input  1  debounced button level from the debouncer, high = pressed, synchronous to clk.
REQ-007 press  output  1  one-clk pulse on an accepted 0->1 edge of btn_db.
REQ-008 short_press  output  1  one-clk pulse on release when the hold lasted fewer than LONG_MS ticks.
REQ-009 long_press  output  1  one-clk pulse when the hold reaches LONG_MS ticks.
REQ-010 repeat_tick  output  1  one-clk auto-repeat pulse; exists only per REQ-024.
REQ-011 held  output  1  registered level, high while state is PRESSED or LONG.

Function
REQ-012 States: ARM, IDLE, PRESSED, LONG; 16-bit tick counter cnt; registered copy btn_q of btn_db for edge detection.
REQ-013 ARM: wait for btn_db=0, then go to IDLE; no output pulses fire in ARM.
REQ-014 IDLE: on btn_db=1 with btn_q=0, go to PRESSED, clear cnt, pulse press in the same cycle as the transition.
REQ-015 PRESSED: each ce1ms increments cnt; when ce1ms is high and cnt = LONG_MS-1, go to LONG, pulse long_press, clear cnt.
REQ-016 PRESSED: btn_db=0 pulses short_press and goes to IDLE.
REQ-017 Simultaneous release and LONG_MS reach in PRESSED: release wins; short_press fires, long_press does not.
REQ-018 LONG: btn_db=0 goes to IDLE with no pulse; short_press never fires after long_press for the same hold.
REQ-019 All outputs are registered, so each pulse appears 1 clk after the causing btn_db/ce1ms sample.
REQ-020 Pulses are exactly 1 clk wide, and at most one of press/short_press/long_press/repeat_tick is high in any cycle.
REQ-021 cnt saturates at 16'hFFFF and never wraps.

Reset
REQ-022 rst_n low: state=ARM, cnt=0, btn_q=1, and press, short_press, long_press, repeat_tick, held all 0, taking effect immediately and asynchronously.
REQ-023 Reset asserted mid-hold aborts the hold with no pulse; a button still held at reset release is ignored until it is released (ARM).

Configuration
REQ-024 Macro BTN_AUTOREPEAT_EN.
- Defined: in LONG, each ce1ms increments cnt; at cnt = REPEAT_MS-1 with ce1ms high, pulse repeat_tick and clear cnt.
- Not defined: repeat_tick is tied to 0 and LONG does not count.

Structure
REQ-025 Package btn_events_pkg holds the state typedef (ARM, IDLE, PRESSED, LONG) and constant CNT_W=16.
REQ-026 Sub-module edge_det (clk, rst_n, d, rise, fall) holds btn_q and produces the edge strobes; it resets btn_q to 1.
REQ-027 The rest of btn_events is the FSM plus counter, with no further sub-modules.

Verification (bench uses LONG_MS=4, REPEAT_MS=2, ce1ms every 12 clk)
REQ-028 Short press: btn_db high for 2 ce1ms ticks, then low -> exactly 1 press, then 1 short_press; long_press=0; held high only during the hold.
REQ-029 Long press: btn_db held for 10 ticks -> press, long_press on the 4th tick, no short_press on release.
REQ-030 Auto-repeat, macro defined, 10-tick hold -> repeat_tick on ticks 6, 8, 10; macro undefined -> repeat_tick stays 0.
REQ-031 Simultaneous events: release in the same clk as the 4th ce1ms -> short_press=1, long_press=0.
REQ-032 Reset:
- rst_n pulsed low mid-hold -> all outputs 0 at once.
- btn_db kept high through reset release -> no pulses.
- btn_db low then high -> press.
REQ-033 Every scenario asserts the one-hot-or-zero pulse rule (REQ-020) on every clk.
